cdm_bus_unit: RTL and testbench
===============================

Name: cdm_bus_unit

Overview:
Parametrised bus interface unit between the CDM core datapath and external memory/IO. It replaces the core's fixed 16-bit, clock-inhibit-based two-phase unaligned access with an explicit request/response FSM. It generalises data width (16/32), splits unaligned accesses into two aligned beats, supports memory wait states via a ready handshake, and reports a bus timeout fault. The core raises its hold line from `busy`.

Parameters:
ADDR_W, 16, byte-address width.
DATA_W, 16, memory data width; legal values are 16 or 32; BYTES = DATA_W/8.
MAX_WAIT, 15, wait cycles allowed per beat before a fault; 0 disables the timeout.

Ports:
input_clock  in  1  single clock; all state updates on posedge.
reset  in  1  asynchronous, active-high reset.
req_valid  in  1  core access request.
req_ready  out  1  high only in IDLE; request accepted when req_valid && req_ready.
req_addr  in  ADDR_W  byte address.
req_write  in  1  1 = write, 0 = read.
req_size  in  2  0 = byte, 1 = half (16b), 2 = word (32b), 3 = illegal.
req_sign_extend  in  1  sign-extend read result from the top byte of the access.
req_data_space  in  1  data (1) / instruction (0) space; forwarded as mem_data.
req_wdata  in  DATA_W  write data, right-aligned.
rsp_valid  out  1  one-cycle completion pulse.
rsp_rdata  out  DATA_W  assembled, extended read data; 0 on writes and faults.
rsp_fault  out  1  qualified by rsp_valid: timeout or illegal size.
busy  out  1  ~IDLE; drives the core's hold.
mem_valid  out  1  beat request.
mem_ready  in  1  beat completes on posedge when mem_valid && mem_ready.
mem_addr  out  ADDR_W  beat address, aligned to BYTES.
mem_read  out  1  beat direction.
mem_data  out  1  latched req_data_space.
mem_byte_en  out  BYTES  active lanes.
mem_wdata  out  DATA_W  lane-shifted write data.
mem_rdata  in  DATA_W  read data, sampled on a beat handshake.

Behaviour:
- Reset (async): state IDLE, counter 0. req_ready=1; all other outputs 0. Asserting reset mid-beat drops mem_valid immediately, with no response.
- States: IDLE, BEAT0, BEAT1, RESP.
- Request latching: in IDLE, an accepted request latches all req_* fields and computes:
  - off = addr mod BYTES;
  - n = 1 << size;
  - split = (off + n > BYTES).
- Illegal size: size == 3, or n > BYTES (size 2 when DATA_W=16). Go directly to RESP with fault=1 and no memory beat.
- BEAT0:
  - mem_addr = addr with the low bits cleared.
  - mem_byte_en = ((1<<n)-1) << off, truncated to BYTES.
  - mem_wdata = wdata << 8*off.
  - On handshake: read lanes are stored; next state is BEAT1 if split, else RESP.
- BEAT1:
  - mem_addr = beat-0 address + BYTES, wrapping modulo 2^ADDR_W.
  - mem_byte_en = remaining low lanes: (1 << (off+n-BYTES)) - 1.
  - mem_wdata = wdata >> 8*(BYTES-off).
  - On handshake: next state is RESP.
- Outputs hold: mem_* outputs are stable while mem_valid && !mem_ready.
- Timeout:
  - A per-beat counter clears on beat entry and increments each cycle without ready.
  - If MAX_WAIT != 0 and the counter == MAX_WAIT with !mem_ready, the beat aborts, BEAT1 is skipped, and the FSM goes to RESP with fault=1.
  - mem_valid is therefore high for MAX_WAIT+1 cycles.
- Read assembly:
  - Beat-0 lanes off..BYTES-1 map to result bytes 0..;
  - beat-1 lanes continue from the next result byte upward.
  - Bits above 8n are zero-filled, or filled with bit 8n-1 if sign_extend.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. A new request can be accepted the cycle after RESP.
- Latency:
  - Aligned, zero-wait access: accept in cycle 0, mem_valid in cycle 1, rsp_valid in cycle 2.
  - A split access adds 1 cycle; each wait cycle adds 1.
- busy is high from the cycle after acceptance through RESP inclusive.

Decomposition:
- Package cdm_bus_pkg:
  - state enum (IDLE/BEAT0/BEAT1/RESP);
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - a function computing byte count from size.
- Sub-module cdm_lane_align (combinational): given off, n and beat index, produces byte_en, the shifted write data, and read-lane placement. It is instantiated once and muxed by beat.

Test Plan:
1. DATA_W=16, half read at 0x0010, mem_rdata=0xBEEF, zero wait -> one beat: addr 0x0010, en 2'b11; rsp_valid in cycle 2 with rdata 0xBEEF.
2. Half read at 0x0011 -> beat0 addr 0x0010, en 2'b10, rdata 0x12AA; beat1 addr 0x0012, en 2'b01, rdata 0xBB34; rsp rdata 0x3412.
3. Byte read at 0x0021, mem_rdata 0x80FF -> sign_extend=1 gives 0xFF80; sign_extend=0 gives 0x0080.
4. Half write at 0xFFFF, wdata 0xA55A -> beat0 0xFFFE, en 2'b10, wdata 0x5A00; beat1 wraps to 0x0000, en 2'b01, wdata 0x00A5.
5. MAX_WAIT=3, mem_ready held 0 -> mem_valid high exactly 4 cycles, then rsp_valid with fault=1 and rdata 0; no BEAT1. Separately, size=2 with DATA_W=16 -> fault and no mem_valid.
6. Reset asserted during BEAT1 of a split read -> mem_valid and busy are 0 immediately and no rsp_valid occurs; after release, an aligned read completes normally. Repeat test 2 with DATA_W=32 at 0x0003 for a 32-bit access.

Source files
------------

// File: rtl/cdm_bus_pkg.sv
// Shared types and helpers for the CDM bus interface unit.
package cdm_bus_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StBeat0,
        StBeat1,
        StResp
    } state_e;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Byte count of an access; size 3 yields 8, which is always rejected as illegal.
    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        return 4'd1 << size;
    endfunction

endpackage

// File: rtl/cdm_lane_align.sv
// Lane steering for one memory beat: byte enables, shifted write data and the
// placement of returned read lanes into the right-aligned result.
module cdm_lane_align #(
    parameter int unsigned DATA_W = 16,
    localparam int unsigned BYTES = DATA_W / 8,
    localparam int unsigned OFF_W = $clog2(BYTES)
) (
    input  logic [OFF_W-1:0]  off,
    input  logic [3:0]        n,
    input  logic              beat,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    output logic [BYTES-1:0]  byte_en,
    output logic [DATA_W-1:0] wdata_lane,
    output logic [DATA_W-1:0] rdata_place
);

    logic [5:0] sh_lo;
    logic [5:0] sh_hi;

    // Beat 0 covers lanes off..off+n-1; beat 1 covers the lanes that spilled past BYTES.
    always_comb begin
        sh_lo = 6'({off, 3'b000});
        sh_hi = 6'(DATA_W) - sh_lo;
        byte_en = '0;
        for (int b = 0; b < int'(BYTES); b++) begin
            if (!beat) begin
                byte_en[b] = (b >= int'(off)) && (b < int'(off) + int'(n));
            end else begin
                byte_en[b] = (b + int'(BYTES) < int'(off) + int'(n));
            end
        end
        if (!beat) begin
            wdata_lane  = wdata << sh_lo;
            rdata_place = rdata >> sh_lo;
        end else begin
            wdata_lane  = wdata >> sh_hi;
            rdata_place = rdata << sh_hi;
        end
    end

endmodule

// File: rtl/cdm_bus_unit.sv
// Request/response bus interface unit: splits unaligned accesses into two
// aligned beats, honours memory wait states and reports bus timeouts.
module cdm_bus_unit
    import cdm_bus_pkg::*;
#(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic                  input_clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_sign_extend,
    input  logic                  req_data_space,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_fault,
    output logic                  busy,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_read,
    output logic                  mem_data,
    output logic [DATA_W/8-1:0]   mem_byte_en,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int unsigned BYTES = DATA_W / 8;
    localparam int unsigned OFF_W = $clog2(BYTES);
    localparam int unsigned CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    state_e              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                write_q;
    logic [3:0]          n_q;
    logic                split_q;
    logic                sext_q;
    logic                space_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   acc_q;
    logic                fault_q;
    logic [CNT_W-1:0]    cnt_q;

    logic [3:0]          req_n;
    logic                req_illegal;
    logic                req_split;
    logic                beat_active;
    logic [ADDR_W-1:0]   beat0_addr;
    logic [BYTES-1:0]    lane_en;
    logic [DATA_W-1:0]   lane_wdata;
    logic [DATA_W-1:0]   lane_rdata;
    logic                sign_bit;
    logic [DATA_W-1:0]   ext_rdata;

    // Decode the incoming request: byte count, legality and whether it crosses a beat.
    always_comb begin
        req_n       = size_bytes(req_size);
        req_illegal = (req_size > SZ_WORD) || (req_n > 4'(BYTES));
        req_split   = (5'(req_addr[OFF_W-1:0]) + 5'(req_n)) > 5'(BYTES);
    end

    cdm_lane_align #(
        .DATA_W(DATA_W)
    ) u_lane_align (
        .off        (addr_q[OFF_W-1:0]),
        .n          (n_q),
        .beat       (state_q == StBeat1),
        .wdata      (wdata_q),
        .rdata      (mem_rdata),
        .byte_en    (lane_en),
        .wdata_lane (lane_wdata),
        .rdata_place(lane_rdata)
    );

    // Access FSM: latch request, run one or two beats with per-beat timeout, respond.
    always_ff @(posedge input_clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            addr_q  <= '0;
            write_q <= 1'b0;
            n_q     <= '0;
            split_q <= 1'b0;
            sext_q  <= 1'b0;
            space_q <= 1'b0;
            wdata_q <= '0;
            acc_q   <= '0;
            fault_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        write_q <= req_write;
                        n_q     <= req_n;
                        split_q <= req_split;
                        sext_q  <= req_sign_extend;
                        space_q <= req_data_space;
                        wdata_q <= req_wdata;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        fault_q <= req_illegal;
                        state_q <= req_illegal ? StResp : StBeat0;
                    end
                end
                StBeat0, StBeat1: begin
                    if (mem_ready) begin
                        if (!write_q) begin
                            acc_q <= acc_q | lane_rdata;
                        end
                        cnt_q   <= '0;
                        state_q <= (state_q == StBeat0 && split_q) ? StBeat1 : StResp;
                    end else if ((MAX_WAIT != 0) && (cnt_q == CNT_MAX)) begin
                        // Abort the whole access; a pending second beat is never issued.
                        fault_q <= 1'b1;
                        state_q <= StResp;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Extend the assembled read result above the accessed bytes.
    always_comb begin
        sign_bit  = 1'b0;
        ext_rdata = '0;
        for (int i = 0; i < int'(BYTES); i++) begin
            if (4'(i + 1) == n_q) begin
                sign_bit = acc_q[8*i+7];
            end
        end
        for (int i = 0; i < int'(BYTES); i++) begin
            if (4'(i) < n_q) begin
                ext_rdata[8*i+:8] = acc_q[8*i+:8];
            end else begin
                ext_rdata[8*i+:8] = {8{sext_q & sign_bit}};
            end
        end
    end

    // Outputs decoded from registered state only, so they hold steady through wait states.
    always_comb begin
        beat_active = (state_q == StBeat0) || (state_q == StBeat1);
        beat0_addr  = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        req_ready   = (state_q == StIdle);
        busy        = (state_q != StIdle);
        mem_valid   = beat_active;
        mem_addr    = '0;
        mem_read    = 1'b0;
        mem_data    = 1'b0;
        mem_byte_en = '0;
        mem_wdata   = '0;
        if (beat_active) begin
            mem_addr    = (state_q == StBeat1) ? beat0_addr + ADDR_W'(BYTES) : beat0_addr;
            mem_read    = !write_q;
            mem_data    = space_q;
            mem_byte_en = lane_en;
            mem_wdata   = lane_wdata;
        end
        rsp_valid = (state_q == StResp);
        rsp_fault = rsp_valid && fault_q;
        rsp_rdata = (rsp_valid && !fault_q && !write_q) ? ext_rdata : '0;
    end

endmodule

// File: tb/tb_cdm_bus_unit.sv
// Self-checking bench for cdm_bus_unit: a 16-bit and a 32-bit instance share a
// byte-addressed memory image; a reference byte-memory predicts every response.
module tb_cdm_bus_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] req_addr;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_sext;
    logic        req_space;
    logic [31:0] req_wdata;

    logic        req_valid16, req_ready16, rsp_valid16, rsp_fault16, busy16;
    logic [15:0] rsp_rdata16, mem_addr16, mem_wdata16, mem_rdata16;
    logic        mem_valid16, mem_ready16, mem_read16, mem_data16;
    logic [1:0]  mem_byte_en16;

    logic        req_valid32, req_ready32, rsp_valid32, rsp_fault32, busy32;
    logic [31:0] rsp_rdata32, mem_wdata32, mem_rdata32;
    logic [15:0] mem_addr32;
    logic        mem_valid32, mem_ready32, mem_read32, mem_data32;
    logic [3:0]  mem_byte_en32;

    logic [7:0]  bus_mem [65536];
    logic [7:0]  ref_mem [65536];

    logic [15:0] lg_addr [4];
    logic [3:0]  lg_en   [4];
    logic [31:0] lg_wd   [4];
    logic        lg_rd   [4];
    logic        lg_sp   [4];

    bit rand_wait;
    bit hold_ready;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cdm_bus_unit #(.ADDR_W(16), .DATA_W(16), .MAX_WAIT(3)) dut16 (
        .input_clock(clk), .reset(rst),
        .req_valid(req_valid16), .req_ready(req_ready16), .req_addr(req_addr),
        .req_write(req_write), .req_size(req_size), .req_sign_extend(req_sext),
        .req_data_space(req_space), .req_wdata(req_wdata[15:0]),
        .rsp_valid(rsp_valid16), .rsp_rdata(rsp_rdata16), .rsp_fault(rsp_fault16),
        .busy(busy16), .mem_valid(mem_valid16), .mem_ready(mem_ready16),
        .mem_addr(mem_addr16), .mem_read(mem_read16), .mem_data(mem_data16),
        .mem_byte_en(mem_byte_en16), .mem_wdata(mem_wdata16), .mem_rdata(mem_rdata16)
    );

    cdm_bus_unit #(.ADDR_W(16), .DATA_W(32), .MAX_WAIT(3)) dut32 (
        .input_clock(clk), .reset(rst),
        .req_valid(req_valid32), .req_ready(req_ready32), .req_addr(req_addr),
        .req_write(req_write), .req_size(req_size), .req_sign_extend(req_sext),
        .req_data_space(req_space), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid32), .rsp_rdata(rsp_rdata32), .rsp_fault(rsp_fault32),
        .busy(busy32), .mem_valid(mem_valid32), .mem_ready(mem_ready32),
        .mem_addr(mem_addr32), .mem_read(mem_read32), .mem_data(mem_data32),
        .mem_byte_en(mem_byte_en32), .mem_wdata(mem_wdata32), .mem_rdata(mem_rdata32)
    );

    // Reference read: n consecutive bytes from the model memory, then extension.
    function automatic logic [31:0] model_read(input logic [15:0] a, input logic [1:0] sz,
                                               input bit sx, input int nb);
        logic [31:0] v;
        int n;
        v = '0;
        n = 1 << sz;
        for (int i = 0; i < n; i++) v[8*i+:8] = ref_mem[a + 16'(i)];
        if (sx && v[8*n-1]) for (int i = n; i < 4; i++) v[8*i+:8] = 8'hFF;
        if (nb == 2) v[31:16] = '0;
        return v;
    endfunction

    task automatic model_write(input logic [15:0] a, input logic [1:0] sz, input logic [31:0] wd);
        for (int i = 0; i < (1 << sz); i++) ref_mem[a + 16'(i)] = wd[8*i+:8];
    endtask

    task automatic preset(input logic [15:0] a, input logic [7:0] v);
        bus_mem[a] = v;
        ref_mem[a] = v;
    endtask

    // One access on the selected DUT; the bench acts as memory at each negedge.
    task automatic do_txn(input bit sel, input logic [15:0] addr, input bit wr,
                          input logic [1:0] size, input bit sext, input bit ds,
                          input logic [31:0] wd, output logic [31:0] rd, output bit flt,
                          output int lat, output int nbt, output int vcyc, output int waits);
        logic        vld, mrd, rdy;
        logic [15:0] ma;
        logic [3:0]  me;
        logic [31:0] mw, rdt;
        int nb, w;
        bit got;
        nb = sel ? 4 : 2;
        rd = '0; flt = 1'b0; lat = 0; nbt = 0; vcyc = 0; waits = 0; got = 1'b0;
        w = rand_wait ? int'($urandom_range(0, 2)) : 0;
        @(negedge clk);
        checks++;
        if ((sel ? req_ready32 : req_ready16) !== 1'b1 || (sel ? rsp_valid32 : rsp_valid16) !== 1'b0)
        begin
            errors++;
            $display("FAIL idle_before_req: ready=%b rsp_valid=%b required ready=1 rsp_valid=0",
                     sel ? req_ready32 : req_ready16, sel ? rsp_valid32 : rsp_valid16);
        end
        req_addr = addr; req_write = wr; req_size = size; req_sext = sext;
        req_space = ds; req_wdata = wd;
        if (sel) req_valid32 = 1'b1; else req_valid16 = 1'b1;
        for (int i = 1; i <= 40 && !got; i++) begin
            @(negedge clk);
            req_valid16 = 1'b0;
            req_valid32 = 1'b0;
            if (sel ? rsp_valid32 : rsp_valid16) begin
                got = 1'b1;
                lat = i;
                rd  = sel ? rsp_rdata32 : {16'h0, rsp_rdata16};
                flt = sel ? rsp_fault32 : rsp_fault16;
            end
            vld = sel ? mem_valid32 : mem_valid16;
            if (vld) begin
                ma  = sel ? mem_addr32 : mem_addr16;
                me  = sel ? mem_byte_en32 : {2'b00, mem_byte_en16};
                mw  = sel ? mem_wdata32 : {16'h0, mem_wdata16};
                mrd = sel ? mem_read32 : mem_read16;
                rdt = '0;
                vcyc++;
                for (int b = 0; b < nb; b++) rdt[8*b+:8] = bus_mem[ma + 16'(b)];
                if (sel) mem_rdata32 = rdt; else mem_rdata16 = rdt[15:0];
                rdy = 1'b0;
                if (hold_ready) begin
                    rdy = 1'b0;
                end else if (w > 0) begin
                    w--;
                    waits++;
                end else begin
                    rdy = 1'b1;
                    if (nbt < 4) begin
                        lg_addr[nbt] = ma; lg_en[nbt] = me; lg_wd[nbt] = mw;
                        lg_rd[nbt] = mrd; lg_sp[nbt] = sel ? mem_data32 : mem_data16;
                    end
                    nbt++;
                    if (!mrd) for (int b = 0; b < nb; b++) if (me[b]) bus_mem[ma + 16'(b)] = mw[8*b+:8];
                    w = rand_wait ? int'($urandom_range(0, 2)) : 0;
                end
                if (sel) mem_ready32 = rdy; else mem_ready16 = rdy;
            end else begin
                mem_ready16 = 1'b0;
                mem_ready32 = 1'b0;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout: no rsp_valid within 40 cycles, required one");
        end
    endtask

    task automatic test_reset();
        logic [56:0] o16;
        logic [90:0] o32;
        o16 = {req_ready16, busy16, rsp_valid16, rsp_fault16, rsp_rdata16, mem_valid16,
               mem_addr16, mem_read16, mem_data16, mem_byte_en16, mem_wdata16};
        o32 = {req_ready32, busy32, rsp_valid32, rsp_fault32, rsp_rdata32, mem_valid32,
               mem_addr32, mem_read32, mem_data32, mem_byte_en32, mem_wdata32};
        checks++;
        if (o16 !== (57'h1 << 56)) begin
            errors++;
            $display("FAIL reset_outputs16: got %h required %h", o16, 57'h1 << 56);
        end
        checks++;
        if (o32 !== (91'h1 << 90)) begin
            errors++;
            $display("FAIL reset_outputs32: got %h required %h", o32, 91'h1 << 90);
        end
    endtask

    task automatic test_aligned_read();
        logic [31:0] rd; bit f; int lat, nbt, vc, wt;
        preset(16'h0010, 8'hEF); preset(16'h0011, 8'hBE);
        do_txn(1'b0, 16'h0010, 1'b0, 2'd1, 1'b0, 1'b1, 32'h0, rd, f, lat, nbt, vc, wt);
        checks++;
        if ({f, rd[15:0], lat, nbt} !== {1'b0, 16'hBEEF, 32'd2, 32'd1}) begin
            errors++;
            $display("FAIL aligned_read: fault=%b rdata=%h lat=%0d beats=%0d required 0 beef 2 1",
                     f, rd[15:0], lat, nbt);
        end
        checks++;
        if ({lg_addr[0], lg_en[0], lg_rd[0], lg_sp[0]} !== {16'h0010, 4'b0011, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL aligned_beat: addr=%h en=%b read=%b data=%b required 0010 0011 1 1",
                     lg_addr[0], lg_en[0], lg_rd[0], lg_sp[0]);
        end
    endtask

    task automatic test_split_read();
        logic [31:0] rd; bit f; int lat, nbt, vc, wt;
        preset(16'h0010, 8'hAA); preset(16'h0011, 8'h12);
        preset(16'h0012, 8'h34); preset(16'h0013, 8'hBB);
        do_txn(1'b0, 16'h0011, 1'b0, 2'd1, 1'b0, 1'b0, 32'h0, rd, f, lat, nbt, vc, wt);
        checks++;
        if ({f, rd[15:0], lat, nbt} !== {1'b0, 16'h3412, 32'd3, 32'd2}) begin
            errors++;
            $display("FAIL split_read: fault=%b rdata=%h lat=%0d beats=%0d required 0 3412 3 2",
                     f, rd[15:0], lat, nbt);
        end
        checks++;
        if ({lg_addr[0], lg_en[0], lg_addr[1], lg_en[1]} !== {16'h0010, 4'b0010, 16'h0012, 4'b0001})
        begin
            errors++;
            $display("FAIL split_beats: %h/%b %h/%b required 0010/0010 0012/0001",
                     lg_addr[0], lg_en[0], lg_addr[1], lg_en[1]);
        end
    endtask

    task automatic test_sign_extend();
        logic [31:0] rd; bit f; int lat, nbt, vc, wt;
        preset(16'h0020, 8'hFF); preset(16'h0021, 8'h80);
        do_txn(1'b0, 16'h0021, 1'b0, 2'd0, 1'b1, 1'b0, 32'h0, rd, f, lat, nbt, vc, wt);
        checks++;
        if (rd !== 32'h0000FF80) begin
            errors++;
            $display("FAIL byte_sext: got %h required 0000ff80", rd);
        end
        do_txn(1'b0, 16'h0021, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0, rd, f, lat, nbt, vc, wt);
        checks++;
        if (rd !== 32'h00000080) begin
            errors++;
            $display("FAIL byte_zext: got %h required 00000080", rd);
        end
    endtask

    task automatic test_wrap_write();
        logic [31:0] rd; bit f; int lat, nbt, vc, wt;
        do_txn(1'b0, 16'hFFFF, 1'b1, 2'd1, 1'b0, 1'b1, 32'h0000A55A, rd, f, lat, nbt, vc, wt);
        model_write(16'hFFFF, 2'd1, 32'h0000A55A);
        checks++;
        if ({lg_addr[0], lg_en[0], lg_wd[0][15:0]} !== {16'hFFFE, 4'b0010, 16'h5A00}) begin
            errors++;
            $display("FAIL wrap_beat0: %h/%b/%h required fffe/0010/5a00",
                     lg_addr[0], lg_en[0], lg_wd[0][15:0]);
        end
        checks++;
        if ({lg_addr[1], lg_en[1], lg_wd[1][15:0], nbt, rd} !==
            {16'h0000, 4'b0001, 16'h00A5, 32'd2, 32'h0}) begin
            errors++;
            $display("FAIL wrap_beat1: %h/%b/%h beats=%0d rdata=%h required 0000/0001/00a5 2 0",
                     lg_addr[1], lg_en[1], lg_wd[1][15:0], nbt, rd);
        end
    endtask

    task automatic test_timeout();
        logic [31:0] rd; bit f; int lat, nbt, vc, wt;
        hold_ready = 1'b1;
        do_txn(1'b0, 16'h0011, 1'b0, 2'd1, 1'b0, 1'b0, 32'h0, rd, f, lat, nbt, vc, wt);
        hold_ready = 1'b0;
        checks++;
        if ({vc, f, rd, nbt, lat} !== {32'd4, 1'b1, 32'h0, 32'd0, 32'd5}) begin
            errors++;
            $display("FAIL timeout: valid_cycles=%0d fault=%b rdata=%h beats=%0d lat=%0d required 4 1 0 0 5",
                     vc, f, rd, nbt, lat);
        end
        do_txn(1'b0, 16'h0010, 1'b0, 2'd2, 1'b0, 1'b0, 32'h0, rd, f, lat, nbt, vc, wt);
        checks++;
        if ({vc, f, rd, lat} !== {32'd0, 1'b1, 32'h0, 32'd1}) begin
            errors++;
            $display("FAIL illegal_size: valid_cycles=%0d fault=%b rdata=%h lat=%0d required 0 1 0 1",
                     vc, f, rd, lat);
        end
    endtask

    task automatic test_reset_mid_beat();
        logic [31:0] rd; bit f; int lat, nbt, vc, wt;
        bit seen;
        preset(16'h0010, 8'hAA); preset(16'h0011, 8'h12);
        preset(16'h0012, 8'h34); preset(16'h0013, 8'hBB);
        @(negedge clk);
        req_addr = 16'h0011; req_write = 1'b0; req_size = 2'd1; req_sext = 1'b0;
        req_valid16 = 1'b1;
        @(negedge clk);
        req_valid16 = 1'b0;
        mem_rdata16 = {bus_mem[16'h0011], bus_mem[16'h0010]};
        mem_ready16 = 1'b1;
        @(negedge clk);
        mem_ready16 = 1'b0;
        checks++;
        if ({mem_valid16, mem_addr16} !== {1'b1, 16'h0012}) begin
            errors++;
            $display("FAIL beat1_before_reset: valid=%b addr=%h required 1 0012", mem_valid16, mem_addr16);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({mem_valid16, busy16, rsp_valid16} !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid_beat: valid/busy/rsp=%b required 000",
                     {mem_valid16, busy16, rsp_valid16});
        end
        seen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            seen |= rsp_valid16;
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen |= rsp_valid16 | !req_ready16;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL no_rsp_after_reset: spurious response or not idle=%b required 0", seen);
        end
        do_txn(1'b0, 16'h0010, 1'b0, 2'd1, 1'b0, 1'b0, 32'h0, rd, f, lat, nbt, vc, wt);
        checks++;
        if ({f, rd, lat} !== {1'b0, 32'h000012AA, 32'd2}) begin
            errors++;
            $display("FAIL read_after_reset: fault=%b rdata=%h lat=%0d required 0 000012aa 2", f, rd, lat);
        end
    endtask

    task automatic test_width32();
        logic [31:0] rd; bit f; int lat, nbt, vc, wt;
        for (int i = 0; i < 8; i++) preset(16'(i), 8'(8'h11 * (i + 1)));
        do_txn(1'b1, 16'h0003, 1'b0, 2'd2, 1'b0, 1'b0, 32'h0, rd, f, lat, nbt, vc, wt);
        checks++;
        if ({rd, lat, lg_addr[0], lg_en[0], lg_addr[1], lg_en[1]} !==
            {32'h77665544, 32'd3, 16'h0000, 4'b1000, 16'h0004, 4'b0111}) begin
            errors++;
            $display("FAIL word_split32: rdata=%h lat=%0d %h/%b %h/%b required 77665544 3 0000/1000 0004/0111",
                     rd, lat, lg_addr[0], lg_en[0], lg_addr[1], lg_en[1]);
        end
        do_txn(1'b1, 16'h0003, 1'b0, 2'd1, 1'b0, 1'b0, 32'h0, rd, f, lat, nbt, vc, wt);
        checks++;
        if ({rd, lg_en[0], lg_en[1], nbt} !== {32'h00005544, 4'b1000, 4'b0001, 32'd2}) begin
            errors++;
            $display("FAIL half_split32: rdata=%h en=%b/%b beats=%0d required 00005544 1000/0001 2",
                     rd, lg_en[0], lg_en[1], nbt);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, exp_rd, wd; bit f, sel, wr, sx, ds, ill;
        logic [15:0] a; logic [1:0] sz;
        int lat, nbt, vc, wt, nb, n, exp_beats, exp_lat, bad;
        rand_wait = 1'b1;
        for (int k = 0; k < 80; k++) begin
            sel = 1'($urandom_range(0, 1));
            nb  = sel ? 4 : 2;
            sz  = 2'($urandom_range(0, 3));
            a   = ($urandom_range(0, 3) == 0) ? 16'hFFF8 + 16'($urandom_range(0, 7))
                                              : 16'h0100 + 16'($urandom_range(0, 31));
            wr = 1'($urandom); sx = 1'($urandom); ds = 1'($urandom); wd = $urandom;
            n = 1 << sz;
            ill = (sz == 2'd3) || (n > nb);
            exp_rd = (ill || wr) ? 32'h0 : model_read(a, sz, sx, nb);
            exp_beats = ill ? 0 : ((int'(a) % nb) + n > nb) ? 2 : 1;
            do_txn(sel, a, wr, sz, sx, ds, wd, rd, f, lat, nbt, vc, wt);
            if (!ill && wr) model_write(a, sz, wd);
            exp_lat = ill ? 1 : 1 + exp_beats + wt;
            checks++;
            if ({f, rd} !== {ill, exp_rd}) begin
                errors++;
                $display("FAIL rand_rsp[%0d]: fault=%b rdata=%h required %b %h (w%0d a=%h sz=%0d wr=%b)",
                         k, f, rd, ill, exp_rd, nb * 8, a, sz, wr);
            end
            checks++;
            if ({nbt, lat} !== {exp_beats, exp_lat}) begin
                errors++;
                $display("FAIL rand_timing[%0d]: beats=%0d lat=%0d required %0d %0d",
                         k, nbt, lat, exp_beats, exp_lat);
            end
            if (nbt > 0) begin
                checks++;
                if ({lg_rd[0], lg_sp[0]} !== {!wr, ds}) begin
                    errors++;
                    $display("FAIL rand_dir[%0d]: read=%b data=%b required %b %b",
                             k, lg_rd[0], lg_sp[0], !wr, ds);
                end
            end
        end
        rand_wait = 1'b0;
        bad = 0;
        for (int i = 0; i < 65536; i++) if (bus_mem[i] !== ref_mem[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL mem_image: %0d differing bytes, required 0", bad);
        end
    endtask

    initial begin
        rst = 1'b1;
        req_valid16 = 1'b0; req_valid32 = 1'b0;
        req_addr = '0; req_write = 1'b0; req_size = '0; req_sext = 1'b0;
        req_space = 1'b0; req_wdata = '0;
        mem_ready16 = 1'b0; mem_ready32 = 1'b0; mem_rdata16 = '0; mem_rdata32 = '0;
        rand_wait = 1'b0; hold_ready = 1'b0;
        for (int i = 0; i < 65536; i++) begin
            bus_mem[i] = 8'($urandom);
            ref_mem[i] = bus_mem[i];
        end
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b0;
        test_aligned_read();
        test_split_read();
        test_sign_extend();
        test_wrap_write();
        test_timeout();
        test_reset_mid_beat();
        test_width32();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
